// File: rtl/nios2_c_key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios2_c_key_pkg
// Description : Shared state encodings and constants for the KEY debouncer.
// Revision    : 1.0  initial release
// ============================================================================
package nios2_c_key_pkg;

    typedef enum logic [0:0] {
        KEY_STABLE   = 1'b0,
        KEY_COUNTING = 1'b1
    } key_state_t;

    localparam int KEY_DEBOUNCE_20MS = 1000000;

    // The counter must be able to represent the full debounce window.
    function automatic bit cnt_w_ok(input int cnt_w, input int cycles);
        return (cnt_w >= 1) && (cnt_w <= 62) && (cycles >= 1) &&
               ((longint'(1) << cnt_w) >= longint'(cycles));
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_c_key_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : nios2_c_key_debounce_if
// Description : Raw key pins in, debounced levels and strobes out.
// Revision    : 1.0  initial release
// ============================================================================
interface nios2_c_key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (output key_raw, input key_level, input key_press, input key_release);
    modport slave  (input key_raw, output key_level, output key_press, output key_release);
endinterface
`default_nettype wire

// File: rtl/nios2_c_key_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : nios2_c_key_debounce_cell
// Description : Synchroniser, stability counter and edge strobes for one key.
// Revision    : 1.0  initial release
// ============================================================================
module nios2_c_key_debounce_cell
    import nios2_c_key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_20MS,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic key_raw,
    output logic      key_level,
    output logic      key_press,
    output logic      key_release
);

    // cnt holds the number of mismatched samples already seen, so the
    // window closes on the sample arriving while cnt == DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sample;
    key_state_t             state;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], key_raw};
        end
    end

    assign sample = sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= KEY_STABLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (sample == key_level) begin
                state <= KEY_STABLE;
                cnt   <= '0;
            end else begin
                case (state)
                    KEY_STABLE: begin
                        if (CNT_LAST == '0) begin
                            key_level   <= sample;
                            key_press   <= sample;
                            key_release <= ~sample;
                        end else begin
                            state <= KEY_COUNTING;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    KEY_COUNTING: begin
                        if (cnt == CNT_LAST) begin
                            state       <= KEY_STABLE;
                            cnt         <= '0;
                            key_level   <= sample;
                            key_press   <= sample;
                            key_release <= ~sample;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= KEY_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios2_c_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : nios2_c_key_debounce
// Description : Debounces NUM_KEYS push-buttons into clean levels and strobes.
// Revision    : 1.0  initial release
// ============================================================================
module nios2_c_key_debounce
    import nios2_c_key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_20MS,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input wire logic               clk,
    input wire logic               reset_n,
    nios2_c_key_debounce_if.slave  keys
);

    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] release_s;

    if (!cnt_w_ok(CNT_W, DEBOUNCE_CYCLES) || (SYNC_STAGES < 2)) begin : g_param_check
        $error("nios2_c_key_debounce: CNT_W/DEBOUNCE_CYCLES/SYNC_STAGES out of range");
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        nios2_c_key_debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_cell (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (keys.key_raw[k]),
            .key_level   (level[k]),
            .key_press   (press[k]),
            .key_release (release_s[k])
        );
    end

    assign keys.key_level   = level;
    assign keys.key_press   = press;
    assign keys.key_release = release_s;

endmodule
`default_nettype wire

// File: tb/tb_nios2_c_key_debounce.sv
`default_nettype none
// Bench for nios2_c_key_debounce: directed vector table, hand-written corner
// sequences, then random per-key bouncing checked against a run-length model.
module tb_nios2_c_key_debounce;

    localparam int NK = 4;
    localparam int SS = 2;
    localparam int DC = 8;
    localparam int CW = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    nios2_c_key_debounce_if #(.NUM_KEYS(NK)) kif ();

    nios2_c_key_debounce #(
        .NUM_KEYS        (NK),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .keys    (kif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] raw;
        int            cycles;
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [NK-1:0] raw, input int cyc,
                       input logic [NK-1:0] l, input logic [NK-1:0] p, input logic [NK-1:0] r);
        vec_t v;
        v.raw = raw; v.cycles = cyc; v.lvl = l; v.prs = p; v.rel = r;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NK-1:0] prev;
        logic [NK-1:0] q[$];
        logic [NK-1:0] cur, smp, mlevel, mpress, mrel;
        int            run[NK];
        int            hold[NK];
        int            found;

        // Reset with all keys "pressed" on the pins: nothing may come out.
        kif.key_raw = '0;
        repeat (3) begin
            tick();
            check("reset level", kif.key_level, 4'h0);
            check("reset press", kif.key_press, 4'h0);
            check("reset release", kif.key_release, 4'h0);
        end
        kif.key_raw = 4'hF;
        tick();
        reset_n = 1'b1;

        add(4'hF,  3, 4'h0, 4'h0, 4'h0);   // idle after reset
        add(4'hE,  9, 4'h0, 4'h0, 4'h0);   // clean press key0
        add(4'hE,  1, 4'h1, 4'h1, 4'h0);
        add(4'hE,  1, 4'h1, 4'h0, 4'h0);
        add(4'hF,  9, 4'h1, 4'h0, 4'h0);   // clean release key0
        add(4'hF,  1, 4'h0, 4'h0, 4'h1);
        add(4'hF,  1, 4'h0, 4'h0, 4'h0);
        add(4'hD,  5, 4'h0, 4'h0, 4'h0);   // bounce key1
        add(4'hF,  2, 4'h0, 4'h0, 4'h0);
        add(4'hD,  9, 4'h0, 4'h0, 4'h0);
        add(4'hD,  1, 4'h2, 4'h2, 4'h0);
        add(4'hD,  2, 4'h2, 4'h0, 4'h0);
        add(4'hF,  9, 4'h2, 4'h0, 4'h0);
        add(4'hF,  1, 4'h0, 4'h0, 4'h2);
        add(4'hF,  1, 4'h0, 4'h0, 4'h0);
        add(4'hB,  7, 4'h0, 4'h0, 4'h0);   // glitch key2
        add(4'hF, 12, 4'h0, 4'h0, 4'h0);
        add(4'h0,  9, 4'h0, 4'h0, 4'h0);   // all keys together
        add(4'h0,  1, 4'hF, 4'hF, 4'h0);
        add(4'h0,  1, 4'hF, 4'h0, 4'h0);
        add(4'hF,  9, 4'hF, 4'h0, 4'h0);
        add(4'hF,  1, 4'h0, 4'h0, 4'hF);
        add(4'hF,  1, 4'h0, 4'h0, 4'h0);

        prev = 4'h0;
        foreach (vecs[i]) begin
            kif.key_raw = vecs[i].raw;
            for (int c = 1; c <= vecs[i].cycles; c++) begin
                tick();
                if (c < vecs[i].cycles) begin
                    check($sformatf("v%0d hold level", i), kif.key_level, prev);
                    check($sformatf("v%0d hold press", i), kif.key_press, 4'h0);
                    check($sformatf("v%0d hold release", i), kif.key_release, 4'h0);
                end
            end
            check($sformatf("v%0d level", i), kif.key_level, vecs[i].lvl);
            check($sformatf("v%0d press", i), kif.key_press, vecs[i].prs);
            check($sformatf("v%0d release", i), kif.key_release, vecs[i].rel);
            prev = vecs[i].lvl;
        end

        // Reset in the middle of a count on key3, key kept held throughout.
        kif.key_raw = 4'h7;
        repeat (5) tick();
        check("midcount level", kif.key_level, 4'h0);
        reset_n = 1'b0;
        repeat (3) begin
            tick();
            check("midreset press", kif.key_press, 4'h0);
            check("midreset release", kif.key_release, 4'h0);
            check("midreset level", kif.key_level, 4'h0);
        end
        reset_n = 1'b1;
        found = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (kif.key_press != 4'h0) begin
                found = c;
                break;
            end
        end
        check("requalify latency", found, 10);
        check("requalify press", kif.key_press, 4'h8);
        check("requalify level", kif.key_level, 4'h8);

        // Random bouncing: each key holds a random level for 1..14 cycles.
        reset_n     = 1'b0;
        kif.key_raw = 4'hF;
        tick();
        tick();
        reset_n = 1'b1;
        q      = '{4'hF, 4'hF};
        mlevel = '0;
        cur    = 4'hF;
        for (int k = 0; k < NK; k++) begin
            run[k]  = 0;
            hold[k] = 0;
        end
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    cur[k]  = 1'($urandom_range(0, 1));
                    hold[k] = int'($urandom_range(1, 14));
                end
                hold[k]--;
            end
            kif.key_raw = cur;
            tick();
            // The debouncer sees each pin SS edges late; pressed = pin low.
            q.push_back(cur);
            smp    = ~q.pop_front();
            mpress = '0;
            mrel   = '0;
            for (int k = 0; k < NK; k++) begin
                run[k] = (smp[k] != mlevel[k]) ? run[k] + 1 : 0;
                if (run[k] == DC) begin
                    mlevel[k] = smp[k];
                    mpress[k] = smp[k];
                    mrel[k]   = ~smp[k];
                    run[k]    = 0;
                end
            end
            check($sformatf("rand%0d level", n), kif.key_level, mlevel);
            check($sformatf("rand%0d press", n), kif.key_press, mpress);
            check($sformatf("rand%0d release", n), kif.key_release, mrel);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
